// File: rtl/bitbakery_tx_scheduler_pkg.sv
// Shared definitions for the bitbakery serial TX scheduler: FSM encodings,
// packet kinds and lengths, and the status-packet checksum.
`timescale 1ns/1ps
package bitbakery_tx_scheduler_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;

  localparam int PKT_LEN_STATUS = 6;
  localparam int PKT_LEN_EVENT  = 3;
  localparam logic [2:0] STAT_LAST = 3'(PKT_LEN_STATUS - 1);
  localparam logic [2:0] EVT_LAST  = 3'(PKT_LEN_EVENT - 1);

  typedef enum logic {
    PKT_STATUS = 1'b0,
    PKT_EVENT  = 1'b1
  } pkt_kind_e;

  function automatic logic [7:0] status_checksum(input logic [7:0] d0, input logic [7:0] d1,
                                                 input logic [7:0] d2, input logic [7:0] d3);
    return d0 ^ d1 ^ d2 ^ d3;
  endfunction

endpackage

// File: rtl/bitbakery_tx_scheduler_if.sv
// Requester / transmitter bus of the TX scheduler. The master modport is the
// scheduler itself; slave is the surrounding game logic plus the UART.
`timescale 1ns/1ps
interface bitbakery_tx_scheduler_if;
  logic        enable;
  logic [7:0]  d0;
  logic [7:0]  d1;
  logic [7:0]  d2;
  logic [7:0]  d3;
  logic        evt_valid;
  logic [7:0]  evt_code;
  logic        evt_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [15:0] pkt_count;
  logic        overrun;

  modport master (
    input  enable, d0, d1, d2, d3, evt_valid, evt_code, tx_done,
    output evt_ready, tx_start, tx_data, busy, pkt_count, overrun
  );

  modport slave (
    output enable, d0, d1, d2, d3, evt_valid, evt_code, tx_done,
    input  evt_ready, tx_start, tx_data, busy, pkt_count, overrun
  );
endinterface

// File: rtl/bitbakery_period_timer.sv
// Free-running period counter with a terminal-count pulse; held at zero while
// disabled or cleared. Shared with other bitbakery blocks.
`timescale 1ns/1ps
module bitbakery_period_timer #(
  parameter int PERIOD_CYCLES = 500000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [23:0] LAST_COUNT = 24'(PERIOD_CYCLES - 1);

  logic [23:0] r_count;
  logic        w_at_last;

  assign w_at_last = (r_count == LAST_COUNT);
  assign o_tick    = i_enable & ~i_clear & w_at_last;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (!i_enable || i_clear || w_at_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 24'd1;
    end
  end

endmodule

// File: rtl/bitbakery_tx_scheduler.sv
// Builds status/event packets and feeds them byte by byte to the shared 8E1
// UART transmitter; arbitration happens only between packets.
`timescale 1ns/1ps
module bitbakery_tx_scheduler
  import bitbakery_tx_scheduler_pkg::*;
#(
  parameter int         PERIOD_CYCLES = 500000,
  parameter logic [7:0] HDR_STATUS    = 8'hA5,
  parameter logic [7:0] HDR_EVENT     = 8'h5A
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  bitbakery_tx_scheduler_if.master   bus
);

  logic [2:0]  r_state;
  pkt_kind_e   r_kind;
  logic        r_stat_passed;
  logic [2:0]  r_idx;
  logic [2:0]  r_last;
  logic [7:0]  r_buf [6];
  logic        r_evt_pend;
  logic [7:0]  r_evt_code;
  logic        r_stat_pend;
  logic [7:0]  r_tx_data;
  logic        r_busy;
  logic [15:0] r_pkt_count;
  logic        r_overrun;

  logic w_tick;
  logic w_start;
  logic w_pick_evt;
  logic w_evt_hs;
  logic w_clr_evt;
  logic w_clr_stat;

  bitbakery_period_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (bus.enable),
    .i_clear  (1'b0),
    .o_tick   (w_tick)
  );

  // A status request skipped in favour of an event wins the next decision.
  assign w_start    = (r_state == ST_IDLE) & bus.enable & (r_evt_pend | r_stat_pend);
  assign w_pick_evt = r_evt_pend & ~(r_stat_pend & r_stat_passed);
  assign w_evt_hs   = bus.evt_valid & ~r_evt_pend;
  assign w_clr_evt  = (r_state == ST_LOAD) & (r_kind == PKT_EVENT);
  assign w_clr_stat = (r_state == ST_LOAD) & (r_kind == PKT_STATUS);

  assign bus.evt_ready = ~r_evt_pend;
  assign bus.tx_start  = (r_state == ST_SEND);
  assign bus.tx_data   = r_tx_data;
  assign bus.busy      = r_busy;
  assign bus.pkt_count = r_pkt_count;
  assign bus.overrun   = r_overrun;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_evt_pend  <= 1'b0;
      r_evt_code  <= '0;
      r_stat_pend <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_clr_evt) begin
        r_evt_pend <= 1'b0;
      end else if (w_evt_hs) begin
        r_evt_pend <= 1'b1;
        r_evt_code <= bus.evt_code;
      end
      // A tick coinciding with the status LOAD re-arms the request without overrun.
      if (w_tick) begin
        if (r_stat_pend && !w_clr_stat) r_overrun <= 1'b1;
        r_stat_pend <= 1'b1;
      end else if (w_clr_stat) begin
        r_stat_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 6; i++) r_buf[i] <= '0;
    end else if (r_state == ST_LOAD) begin
      if (r_kind == PKT_STATUS) begin
        r_buf[0] <= HDR_STATUS;
        r_buf[1] <= bus.d0;
        r_buf[2] <= bus.d1;
        r_buf[3] <= bus.d2;
        r_buf[4] <= bus.d3;
        r_buf[5] <= status_checksum(bus.d0, bus.d1, bus.d2, bus.d3);
      end else begin
        r_buf[0] <= HDR_EVENT;
        r_buf[1] <= r_evt_code;
        r_buf[2] <= ~r_evt_code;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_kind        <= PKT_STATUS;
      r_stat_passed <= 1'b0;
      r_idx         <= '0;
      r_last        <= '0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
      r_pkt_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state       <= ST_LOAD;
            r_kind        <= w_pick_evt ? PKT_EVENT : PKT_STATUS;
            r_stat_passed <= w_pick_evt & r_stat_pend;
          end
        end
        ST_LOAD: begin
          r_idx     <= '0;
          r_busy    <= 1'b1;
          r_last    <= (r_kind == PKT_EVENT) ? EVT_LAST : STAT_LAST;
          r_tx_data <= (r_kind == PKT_EVENT) ? HDR_EVENT : HDR_STATUS;
          r_state   <= ST_SEND;
        end
        ST_SEND: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.tx_done) r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_idx == r_last) begin
            r_pkt_count <= r_pkt_count + 16'd1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_idx     <= r_idx + 3'd1;
            r_tx_data <= r_buf[r_idx + 3'd1];
            r_state   <= ST_SEND;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitbakery_tx_scheduler.sv
// Directed bench for bitbakery_tx_scheduler with a 20-cycle UART model and a
// 1000-cycle status period.
`timescale 1ns/1ps
module tb_bitbakery_tx_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   tx_delay;
  int   tx_cnt;
  logic [7:0] q [$];

  bitbakery_tx_scheduler_if ifc ();

  bitbakery_tx_scheduler #(
    .PERIOD_CYCLES (1000),
    .HDR_STATUS    (8'hA5),
    .HDR_EVENT     (8'h5A)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // Transmitter model: logs each started byte, answers tx_done tx_delay cycles later.
  initial begin
    tx_cnt = 0;
    ifc.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_cnt = 0;
        ifc.tx_done = 1'b0;
      end else begin
        ifc.tx_done = 1'b0;
        if (tx_cnt > 0) begin
          tx_cnt = tx_cnt - 1;
          if (tx_cnt == 0) ifc.tx_done = 1'b1;
        end
        if (ifc.tx_start === 1'b1) begin
          q.push_back(ifc.tx_data);
          tx_cnt = tx_delay;
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_tx_start(input int budget, output int n);
    n = 0;
    while (ifc.tx_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_pkts(input logic [15:0] target, input int budget, output bit ok);
    int k;
    k = 0;
    while (ifc.pkt_count !== target && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (ifc.pkt_count === target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (ifc.evt_ready !== 1'b1) begin failures++; $display("FAIL reset_evt_ready got=%0b exp=1", ifc.evt_ready); end
    if (ifc.tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%0b exp=0", ifc.tx_start); end
    if (ifc.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", ifc.tx_data); end
    if (ifc.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", ifc.busy); end
    if (ifc.pkt_count !== 16'd0) begin failures++; $display("FAIL reset_pkt_count got=%0d exp=0", ifc.pkt_count); end
    if (ifc.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", ifc.overrun); end
  endtask

  task automatic test_status_period();
    logic [7:0] exp [6];
    logic [7:0] got;
    int n;
    bit ok;
    exp = '{8'hA5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h04};
    q.delete();
    rst_n = 1'b1;
    wait_tx_start(1100, n);
    checks++;
    if (n !== 1002) begin failures++; $display("FAIL status_first_start_cycle got=%0d exp=1002", n); end
    wait_pkts(16'd1, 400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL status_pkt_count got=%0d exp=1", ifc.pkt_count); end
    for (int i = 0; i < 6; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL status_byte%0d got=%0h exp=%0h", i, got, exp[i]); end
    end
    checks += 2;
    if (ifc.overrun !== 1'b0) begin failures++; $display("FAIL status_overrun got=%0b exp=0", ifc.overrun); end
    if (ifc.busy !== 1'b0) begin failures++; $display("FAIL status_busy_end got=%0b exp=0", ifc.busy); end
  endtask

  task automatic test_event();
    logic [7:0] exp [3];
    logic [7:0] got;
    bit ok;
    exp = '{8'h5A, 8'h3C, 8'hC3};
    q.delete();
    @(negedge clk);
    ifc.evt_valid = 1'b1;
    ifc.evt_code  = 8'h3C;
    @(negedge clk);
    ifc.evt_valid = 1'b0;
    checks++;
    if (ifc.evt_ready !== 1'b0) begin failures++; $display("FAIL event_ready_drop got=%0b exp=0", ifc.evt_ready); end
    @(negedge clk);
    checks++;
    if (ifc.evt_ready !== 1'b0) begin failures++; $display("FAIL event_ready_in_load got=%0b exp=0", ifc.evt_ready); end
    @(negedge clk);
    checks += 2;
    if (ifc.tx_start !== 1'b1) begin failures++; $display("FAIL event_start_latency got=%0b exp=1", ifc.tx_start); end
    if (ifc.evt_ready !== 1'b1) begin failures++; $display("FAIL event_ready_back got=%0b exp=1", ifc.evt_ready); end
    wait_pkts(16'd2, 300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL event_pkt_count got=%0d exp=2", ifc.pkt_count); end
    for (int i = 0; i < 3; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL event_byte%0d got=%0h exp=%0h", i, got, exp[i]); end
    end
  endtask

  task automatic test_tie();
    logic [7:0] exp [12];
    logic [7:0] got;
    bit ok;
    exp = '{8'h5A, 8'h11, 8'hEE,
            8'hA5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h04,
            8'h5A, 8'h80, 8'h7F};
    q.delete();
    wait_cyc(1999);
    ifc.evt_valid = 1'b1;
    ifc.evt_code  = 8'h11;
    @(negedge clk);
    ifc.evt_valid = 1'b0;
    wait_cyc(2010);
    ifc.evt_valid = 1'b1;
    ifc.evt_code  = 8'h80;
    @(negedge clk);
    ifc.evt_valid = 1'b0;
    checks++;
    if (ifc.evt_ready !== 1'b0) begin failures++; $display("FAIL tie_second_event_captured got=%0b exp=0", ifc.evt_ready); end
    wait_pkts(16'd5, 700, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tie_pkt_count got=%0d exp=5", ifc.pkt_count); end
    for (int i = 0; i < 12; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL tie_byte%0d got=%0h exp=%0h", i, got, exp[i]); end
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] exp [6];
    logic [7:0] got;
    int n;
    bit ok;
    exp = '{8'hA5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h04};
    wait_cyc(2990);
    q.delete();
    wait_tx_start(50, n);
    checks++;
    if (ifc.tx_start !== 1'b1) begin failures++; $display("FAIL snap_start_timeout got=%0b exp=1", ifc.tx_start); end
    ifc.d0 = 8'h7F;
    wait_pkts(16'd6, 300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL snap_pkt_count got=%0d exp=6", ifc.pkt_count); end
    for (int i = 0; i < 6; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL snap_byte%0d got=%0h exp=%0h", i, got, exp[i]); end
    end
    ifc.d0 = 8'h41;
  endtask

  task automatic test_overrun();
    wait_cyc(3900);
    q.delete();
    tx_delay = 2500;
    wait_cyc(5500);
    checks += 2;
    if (ifc.overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%0b exp=0", ifc.overrun); end
    if (ifc.busy !== 1'b1) begin failures++; $display("FAIL ovr_busy_stalled got=%0b exp=1", ifc.busy); end
    wait_cyc(6010);
    tx_delay = 20;
    checks++;
    if (ifc.overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b exp=1", ifc.overrun); end
    wait_cyc(6990);
    checks += 5;
    if (ifc.pkt_count !== 16'd8) begin failures++; $display("FAIL ovr_one_extra_pkt got=%0d exp=8", ifc.pkt_count); end
    if (ifc.overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", ifc.overrun); end
    if (ifc.busy !== 1'b0) begin failures++; $display("FAIL ovr_idle_after got=%0b exp=0", ifc.busy); end
    if (q.size() !== 12) begin failures++; $display("FAIL ovr_byte_total got=%0d exp=12", q.size()); end
    if (q.size() > 6 && q[6] !== 8'hA5) begin failures++; $display("FAIL ovr_extra_hdr got=%0h exp=a5", q[6]); end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    bit ok;
    wait_cyc(7010);
    checks++;
    if (ifc.busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%0b exp=1", ifc.busy); end
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (ifc.tx_start !== 1'b0) begin failures++; $display("FAIL rstmid_tx_start got=%0b exp=0", ifc.tx_start); end
    if (ifc.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", ifc.busy); end
    if (ifc.pkt_count !== 16'd0) begin failures++; $display("FAIL rstmid_pkt_count got=%0d exp=0", ifc.pkt_count); end
    if (ifc.overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun got=%0b exp=0", ifc.overrun); end
    if (ifc.tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx_data got=%0h exp=0", ifc.tx_data); end
    if (ifc.evt_ready !== 1'b1) begin failures++; $display("FAIL rstmid_evt_ready got=%0b exp=1", ifc.evt_ready); end
    repeat (3) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    wait_tx_start(1100, n);
    checks += 3;
    if (n !== 1002) begin failures++; $display("FAIL rstmid_restart_cycle got=%0d exp=1002", n); end
    if (ifc.tx_data !== 8'hA5) begin failures++; $display("FAIL rstmid_restart_hdr got=%0h exp=a5", ifc.tx_data); end
    if (ifc.busy !== 1'b1) begin failures++; $display("FAIL rstmid_restart_busy got=%0b exp=1", ifc.busy); end
    wait_pkts(16'd1, 300, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL rstmid_pkt_count got=%0d exp=1", ifc.pkt_count); end
    if (q.size() > 5 && q[5] !== 8'h04) begin failures++; $display("FAIL rstmid_checksum got=%0h exp=04", q[5]); end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    tx_delay      = 20;
    rst_n         = 1'b0;
    ifc.enable    = 1'b1;
    ifc.d0        = 8'h41;
    ifc.d1        = 8'h42;
    ifc.d2        = 8'h43;
    ifc.d3        = 8'h44;
    ifc.evt_valid = 1'b0;
    ifc.evt_code  = 8'h00;
    test_reset();
    test_status_period();
    test_event();
    test_tie();
    test_snapshot();
    test_overrun();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
